// File: rtl/tsn_dgcl_rd_splitter.sv
// DGCL read-path splitter: cuts read requests into 4 KiB-safe bursts under an in-flight cap
// and forwards returning beats to the DPRAM buffer. `TSN_DGCL_RD_CHK_EN adds the sticky err checker.
module tsn_dgcl_rd_splitter #(
  parameter int MAX_BURST    = 256,
  parameter int MAX_INFLIGHT = 1024
) (
  input  logic         gemmini_clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [39:0]  req_dram_addr,
  input  logic [15:0]  req_dpram_addr,
  input  logic [15:0]  req_length,
  output logic [39:0]  rcc_dram_addr,
  output logic [15:0]  rcc_dpram_addr,
  output logic [15:0]  rcc_length,
  output logic         rcc_valid,
  input  logic         rcc_ready,
  input  logic [15:0]  rcd_dpram_addr,
  input  logic [127:0] rcd_read_data,
  input  logic [15:0]  rcd_length,
  input  logic         rcd_valid,
  output logic         rcd_ready,
  output logic         buf_wr_en,
  output logic [15:0]  buf_wr_addr,
  output logic [127:0] buf_wr_data,
  input  logic         buf_wr_ready,
  output logic         busy,
  output logic         done
`ifdef TSN_DGCL_RD_CHK_EN
  ,
  output logic         err
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  localparam logic [16:0] BURST_C = 17'(MAX_BURST);
  localparam logic [17:0] INFL_C  = 18'(MAX_INFLIGHT);

  state_t         state_q, state_d;
  logic [39:0]    addr_q, addr_d;
  logic [15:0]    daddr_q, daddr_d;
  logic [15:0]    remaining_q, remaining_d;
  logic [15:0]    total_q, total_d;
  logic [16:0]    issued_q, issued_d;
  logic [16:0]    received_q, received_d;
  logic           wr_en_q, wr_en_d;
  logic [15:0]    wr_addr_q, wr_addr_d;
  logic [127:0]   wr_data_q, wr_data_d;
  logic           done_q, done_d;

  logic [16:0]    rem_s, page_s, lim_s, chunk_s;
  logic           inflight_ok_s, beat_phase_s;
  logic           req_hs_s, rcc_hs_s, rcd_hs_s, rcd_ready_s, rcc_valid_s;

  // Burst never exceeds the remainder, the burst cap, or the distance to the next 4 KiB page.
  assign rem_s   = {1'b0, remaining_q};
  assign page_s  = 17'd4096 - {5'd0, addr_q[11:0]};
  assign lim_s   = (BURST_C < rem_s) ? BURST_C : rem_s;
  assign chunk_s = (page_s < lim_s) ? page_s : lim_s;

  // Rewritten as a sum so a late beat can never underflow the in-flight difference.
  assign inflight_ok_s = ({1'b0, issued_q} + {1'b0, chunk_s}) <= (INFL_C + {1'b0, received_q});

  assign beat_phase_s = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign rcd_ready_s  = beat_phase_s && (!wr_en_q || buf_wr_ready);
  assign rcc_valid_s  = (state_q == ST_ISSUE) && inflight_ok_s;
  assign req_hs_s     = req_valid && (state_q == ST_IDLE);
  assign rcc_hs_s     = rcc_valid_s && rcc_ready;
  assign rcd_hs_s     = rcd_valid && rcd_ready_s;

  assign req_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign rcc_valid      = rcc_valid_s;
  assign rcc_dram_addr  = addr_q;
  assign rcc_dpram_addr = daddr_q;
  assign rcc_length     = chunk_s[15:0];
  assign rcd_ready      = rcd_ready_s;
  assign buf_wr_en      = wr_en_q;
  assign buf_wr_addr    = wr_addr_q;
  assign buf_wr_data    = wr_data_q;

  // Next-state logic for the command FSM, the byte counters and the buffer write stage.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    daddr_d     = daddr_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    issued_d    = issued_q;
    received_d  = rcd_hs_s ? (received_q + 17'd16) : received_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (req_hs_s) begin
          addr_d      = {req_dram_addr[39:4], 4'd0};
          daddr_d     = {req_dpram_addr[15:4], 4'd0};
          remaining_d = {req_length[15:4], 4'd0};
          total_d     = {req_length[15:4], 4'd0};
          issued_d    = 17'd0;
          received_d  = 17'd0;
          state_d     = (req_length[15:4] == 12'd0) ? ST_DONE : ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (rcc_hs_s) begin
          addr_d      = addr_q + {23'd0, chunk_s};
          daddr_d     = daddr_q + chunk_s[15:0];
          remaining_d = remaining_q - chunk_s[15:0];
          issued_d    = issued_q + chunk_s;
          state_d     = (remaining_q == chunk_s[15:0]) ? ST_WAIT : ST_ISSUE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if ((received_q == {1'b0, total_q}) && !wr_en_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Refill in the same cycle as a drain keeps one beat per cycle flowing.
    if (rcd_hs_s) begin
      wr_en_d   = 1'b1;
      wr_addr_d = rcd_dpram_addr;
      wr_data_d = rcd_read_data;
    end else if (buf_wr_ready) begin
      wr_en_d = 1'b0;
    end else begin
      wr_en_d = wr_en_q;
    end

    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge gemmini_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= 40'd0;
      daddr_q     <= 16'd0;
      remaining_q <= 16'd0;
      total_q     <= 16'd0;
      issued_q    <= 17'd0;
      received_q  <= 17'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 16'd0;
      wr_data_q   <= 128'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      daddr_q     <= daddr_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      issued_q    <= issued_d;
      received_q  <= received_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
    end
  end

`ifdef TSN_DGCL_RD_CHK_EN
  logic [15:0] start_daddr_q, start_daddr_d;
  logic        err_q, err_d;
  logic        beat_bad_s;

  assign beat_bad_s = (rcd_dpram_addr != (start_daddr_q + received_q[15:0])) ||
                      (rcd_length != 16'd16) ||
                      ((received_q + 17'd16) > {1'b0, total_q});

  // Sticky protocol checker on accepted beats and stray beats while idle.
  always_comb begin
    start_daddr_d = req_hs_s ? {req_dpram_addr[15:4], 4'd0} : start_daddr_q;
    err_d = err_q || (rcd_hs_s && beat_bad_s) || ((state_q == ST_IDLE) && rcd_valid);
  end

  // Checker registers.
  always_ff @(posedge gemmini_clk or negedge reset) begin
    if (!reset) begin
      start_daddr_q <= 16'd0;
      err_q         <= 1'b0;
    end else begin
      start_daddr_q <= start_daddr_d;
      err_q         <= err_d;
    end
  end

  assign err = err_q;

  logic unused_s;
  assign unused_s = ^{req_dram_addr[3:0], req_length[3:0]};
`else
  logic unused_s;
  assign unused_s = ^{rcd_length, req_dram_addr[3:0], req_dpram_addr[3:0], req_length[3:0]};
`endif

endmodule

// File: tb/tb_tsn_dgcl_rd_splitter.sv
// Scoreboard bench for tsn_dgcl_rd_splitter: a request-level model predicts bursts, flow control,
// buffer writes and done timing; a negedge monitor compares. `TSN_DGCL_RD_CHK_EN adds err checks.
module tb_tsn_dgcl_rd_splitter;
  localparam int MB = 256;
  localparam int MI = 1024;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready;
  logic [39:0]  req_dram_addr;
  logic [15:0]  req_dpram_addr, req_length;
  logic [39:0]  rcc_dram_addr;
  logic [15:0]  rcc_dpram_addr, rcc_length;
  logic         rcc_valid, rcc_ready;
  logic [15:0]  rcd_dpram_addr, rcd_length;
  logic [127:0] rcd_read_data;
  logic         rcd_valid, rcd_ready;
  logic         buf_wr_en, buf_wr_ready;
  logic [15:0]  buf_wr_addr;
  logic [127:0] buf_wr_data;
  logic         busy, done;
`ifdef TSN_DGCL_RD_CHK_EN
  logic         err;
`endif

  always #5 clk = ~clk;

  tsn_dgcl_rd_splitter #(.MAX_BURST(MB), .MAX_INFLIGHT(MI)) dut (
    .gemmini_clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_dram_addr(req_dram_addr),
    .req_dpram_addr(req_dpram_addr), .req_length(req_length),
    .rcc_dram_addr(rcc_dram_addr), .rcc_dpram_addr(rcc_dpram_addr), .rcc_length(rcc_length),
    .rcc_valid(rcc_valid), .rcc_ready(rcc_ready),
    .rcd_dpram_addr(rcd_dpram_addr), .rcd_read_data(rcd_read_data), .rcd_length(rcd_length),
    .rcd_valid(rcd_valid), .rcd_ready(rcd_ready),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_wr_ready(buf_wr_ready), .busy(busy), .done(done)
`ifdef TSN_DGCL_RD_CHK_EN
    , .err(err)
`endif
  );

  typedef struct { logic [39:0] a; logic [15:0] d; logic [15:0] l; } cmd_t;
  typedef struct { logic [15:0] a; logic [127:0] data; } beat_t;

  cmd_t  cmd_q[$];
  beat_t beat_q[$];
  beat_t wr_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, done_due = -1, done_cnt = 0;
  int issued = 0, received = 0, total = 0;
  bit active = 0, beat_hs = 0, hold_beats = 0, rnd = 0, wr_stall = 0, corrupt = 0, err_exp = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: split by the remainder, the burst cap and the 4 KiB page distance.
  function automatic void plan(input logic [39:0] a, input logic [15:0] d, input logic [15:0] l);
    logic [39:0] aa;
    logic [15:0] dd;
    int r, c;
    aa = a & ~40'hF;
    dd = d & ~16'hF;
    r = int'(l & 16'hFFF0);
    total = r;
    while (r > 0) begin
      c = r;
      if (c > MB) c = MB;
      if (c > 4096 - int'(aa[11:0])) c = 4096 - int'(aa[11:0]);
      cmd_q.push_back('{aa, dd, 16'(c)});
      aa = aa + 40'(c);
      dd = dd + 16'(c);
      r = r - c;
    end
  endfunction

  cmd_t  mc;
  beat_t mw;
  bit    drained;
  int    exp_rccv;

  // Monitor: compare outputs with the model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    if (reset) begin
      cyc++;
      chk("busy", busy, active);
      chk("req_ready", req_ready, !active);
      chk("done", done, cyc == done_due);
      exp_rccv = (cmd_q.size() > 0) && (issued - received + int'(cmd_q[0].l) <= MI);
      chk("rcc_valid", rcc_valid, exp_rccv);
      chk("buf_wr_en", buf_wr_en, wr_q.size() > 0);
      chk("rcd_ready", rcd_ready, active && (cyc != done_due) && (wr_q.size() == 0 || buf_wr_ready));
`ifdef TSN_DGCL_RD_CHK_EN
      chk("err", err, err_exp);
`endif
      if (done) done_cnt++;
      if (rcc_valid && rcc_ready && cmd_q.size() > 0) begin
        mc = cmd_q.pop_front();
        chk("rcc_dram_addr", rcc_dram_addr, mc.a);
        chk("rcc_dpram_addr", rcc_dpram_addr, mc.d);
        chk("rcc_length", rcc_length, mc.l);
        issued += int'(mc.l);
        for (int k = 0; k < int'(mc.l) / 16; k++)
          beat_q.push_back('{mc.d + 16'(16 * k), {$urandom, $urandom, $urandom, $urandom}});
      end
      drained = 0;
      if (buf_wr_en && buf_wr_ready && wr_q.size() > 0) begin
        mw = wr_q.pop_front();
        chk("buf_wr_addr", buf_wr_addr, mw.a);
        chk("buf_wr_data", buf_wr_data, mw.data);
        drained = 1;
      end
      if (rcd_valid && rcd_ready) begin
        received += 16;
        wr_q.push_back('{rcd_dpram_addr, rcd_read_data});
        if (beat_q.size() > 0 && rcd_dpram_addr != beat_q[0].a) err_exp = 1;
        beat_hs = 1;
      end
      if (cyc == done_due) active = 0;
      if (drained && wr_q.size() == 0 && cmd_q.size() == 0 && received == total && total > 0)
        done_due = cyc + 2;
      if (req_valid && req_ready) begin
        active = 1;
        issued = 0;
        received = 0;
        plan(req_dram_addr, req_dpram_addr, req_length);
        if (total == 0) done_due = cyc + 1;
      end
    end
  end

  // Driver: readies and return beats, changed just after each rising edge.
  initial begin
    rcd_valid = 0; rcd_dpram_addr = 0; rcd_read_data = 0; rcd_length = 0;
    rcc_ready = 0; buf_wr_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        rcd_valid = 0;
        beat_hs = 0;
      end else begin
        if (beat_hs) begin
          if (beat_q.size() > 0) void'(beat_q.pop_front());
          rcd_valid = 0;
          beat_hs = 0;
        end
        if (!rcd_valid && !hold_beats && beat_q.size() > 0 && (!rnd || $urandom_range(3) != 0)) begin
          rcd_valid = 1;
          rcd_dpram_addr = beat_q[0].a ^ (corrupt ? 16'h0010 : 16'h0000);
          corrupt = 0;
          rcd_read_data = beat_q[0].data;
          rcd_length = 16'd16;
        end
        rcc_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
        buf_wr_ready = wr_stall ? 1'b0 : (rnd ? ($urandom_range(3) != 0) : 1'b1);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (active && t < 5000) begin @(posedge clk); t++; end
    checks++;
    if (active) begin
      errors++;
      $display("FAIL transfer_timeout actual=busy required=done within 5000 cycles");
    end
  endtask

  task automatic do_req(input logic [39:0] a, input logic [15:0] d, input logic [15:0] l, input bit wait_done);
    int t = 0;
    @(posedge clk); #1;
    while (active && t < 5000) begin @(posedge clk); #1; t++; end
    req_dram_addr = a; req_dpram_addr = d; req_length = l; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    if (wait_done) wait_idle();
  endtask

  task automatic clear_model();
    cmd_q.delete(); beat_q.delete(); wr_q.delete();
    active = 0; done_due = -1; err_exp = 0; issued = 0; received = 0; total = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_rcc_valid"}, rcc_valid, 1'b0);
    chk({tag, "_rcd_ready"}, rcd_ready, 1'b0);
    chk({tag, "_buf_wr_en"}, buf_wr_en, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_buf_wr_addr"}, buf_wr_addr, 16'h0);
    chk({tag, "_rcc_dram_addr"}, rcc_dram_addr, 40'h0);
`ifdef TSN_DGCL_RD_CHK_EN
    chk({tag, "_err"}, err, 1'b0);
`endif
  endtask

  initial begin
    int t;
    reset = 0; req_valid = 0; req_dram_addr = 0; req_dpram_addr = 0; req_length = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    chk("por_rcc_length", rcc_length, 16'h0);
    chk("por_buf_wr_data", buf_wr_data, 128'h0);
    @(posedge clk); #1 reset = 1;

    do_req(40'h00_0000_1000, 16'h0000, 16'h0400, 1);
    chk("done_count_4k", done_cnt, 1);
    do_req(40'h00_0000_0FC0, 16'h0100, 16'h0100, 1);

    hold_beats = 1;
    do_req(40'h00_0000_2000, 16'h0000, 16'h0800, 0);
    repeat (20) @(posedge clk);
    chk("inflight_cap_issued", issued, 1024);
    hold_beats = 0;
    wait_idle();

    do_req(40'h00_0000_3000, 16'h0200, 16'h0400, 0);
    repeat (15) @(posedge clk);
    @(negedge clk) wr_stall = 1;
    repeat (5) @(negedge clk);
    wr_stall = 0;
    wait_idle();

    t = done_cnt;
    do_req(40'h00_0000_5000, 16'h0000, 16'h000F, 1);
    chk("zero_len_done_count", done_cnt - t, 1);

    rnd = 1;
    for (int i = 0; i < 15; i++)
      do_req({8'($urandom_range(255)), $urandom}, 16'($urandom), 16'($urandom_range(1536)), 1);
    rnd = 0;

    hold_beats = 1;
    do_req(40'h00_0000_7F80, 16'h0040, 16'h0100, 0);
    t = 0;
    while (cmd_q.size() > 0 && t < 200) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1 reset = 0;
    clear_model();
    #2 chk_reset_outputs("midrst");
    hold_beats = 0;
    t = done_cnt;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    repeat (5) @(posedge clk);
    chk("midrst_no_done", done_cnt - t, 0);
    do_req(40'h00_0000_9000, 16'h0800, 16'h0200, 1);

`ifdef TSN_DGCL_RD_CHK_EN
    do_req(40'h00_0000_A000, 16'h0000, 16'h0100, 0);
    repeat (4) @(posedge clk);
    @(negedge clk) corrupt = 1;
    wait_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("err_sticky_after_done", err, 1'b1);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
